// File: rtl/command_executor.sv
// command_executor: turns decoded host commands into memory accesses and
// sends the response bytes (ACK, NAK or read data) to a UART transmitter.
// Optional feature macro: EXEC_WRITE_ECHO_EN. When it is defined, each write
// reads the same address back and sends ACK followed by the 4 read-back bytes.
module command_executor #(
  parameter logic [7:0] ACK_BYTE = 8'h06,
  parameter logic [7:0] NAK_BASE = 8'hE0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] i_address,
  input  logic [31:0] i_data,
  input  logic        i_readwrite,
  input  logic [1:0]  i_error,
  input  logic        i_done,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [14:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_start,
  input  logic        i_tx_busy,
  output logic        o_busy,
  output logic        o_dropped,
  output logic [3:0]  o_state
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    WRITE      = 4'd1,
    READ       = 4'd2,
    READ_LATCH = 4'd3,
    SEND_START = 4'd4,
    SEND_GUARD = 4'd5,
    SEND_WAIT  = 4'd6,
    DONE       = 4'd7
  } state_t;

`ifdef EXEC_WRITE_ECHO_EN
  localparam bit ECHO_EN = 1'b1;
`else
  localparam bit ECHO_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [14:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] shift_q, shift_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        single_q, single_d;
  logic        ack_first_q, ack_first_d;
  logic        dropped_q, dropped_d;

  // Next-state logic: command acceptance, memory sequencing and the
  // byte-by-byte transmit handshake with the UART.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    tx_byte_d   = tx_byte_q;
    cnt_d       = cnt_q;
    single_d    = single_q;
    ack_first_d = ack_first_q;
    dropped_d   = i_done && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (i_done) begin
          addr_d      = i_address;
          wdata_d     = i_data;
          cnt_d       = 2'd0;
          single_d    = 1'b0;
          ack_first_d = 1'b0;
          if (i_error != 2'd0) begin
            tx_byte_d = NAK_BASE | {6'b0, i_error};
            single_d  = 1'b1;
            state_d   = SEND_START;
          end else if (i_readwrite) begin
            state_d = READ;
          end else begin
            single_d    = !ECHO_EN;
            ack_first_d = ECHO_EN;
            state_d     = WRITE;
          end
        end
      end
      WRITE: begin
        if (ECHO_EN) begin
          state_d = READ;
        end else begin
          tx_byte_d = ACK_BYTE;
          state_d   = SEND_START;
        end
      end
      READ: state_d = READ_LATCH;
      READ_LATCH: begin
        shift_d   = i_mem_rdata;
        tx_byte_d = ack_first_q ? ACK_BYTE : i_mem_rdata[7:0];
        state_d   = SEND_START;
      end
      SEND_START: begin
        if (!i_tx_busy) state_d = SEND_GUARD;
      end
      SEND_GUARD: state_d = SEND_WAIT;
      SEND_WAIT: begin
        if (!i_tx_busy) begin
          if (single_q) begin
            state_d = DONE;
          end else if (ack_first_q) begin
            ack_first_d = 1'b0;
            tx_byte_d   = shift_q[7:0];
            state_d     = SEND_START;
          end else if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = DONE;
          end else begin
            cnt_d     = cnt_q + 2'd1;
            shift_d   = {8'h00, shift_q[31:8]};
            tx_byte_d = shift_q[15:8];
            state_d   = SEND_START;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything so all outputs read 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      shift_q     <= '0;
      tx_byte_q   <= '0;
      cnt_q       <= '0;
      single_q    <= 1'b0;
      ack_first_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      tx_byte_q   <= tx_byte_d;
      cnt_q       <= cnt_d;
      single_q    <= single_d;
      ack_first_q <= ack_first_d;
      dropped_q   <= dropped_d;
    end
  end

  assign o_mem_en    = (state_q == WRITE) || (state_q == READ);
  assign o_mem_we    = (state_q == WRITE);
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_tx_byte   = tx_byte_q;
  assign o_tx_start  = (state_q == SEND_START) && !i_tx_busy;
  assign o_busy      = (state_q != IDLE);
  assign o_dropped   = dropped_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_command_executor.sv
// tb_command_executor: drives command_executor with directed and random
// commands, models memory and a UART transmitter, and compares each response
// against a behavioural reference.
module tb_command_executor;

  logic        clock = 1'b0;
  logic        reset;
  logic [14:0] i_address;
  logic [31:0] i_data;
  logic        i_readwrite;
  logic [1:0]  i_error;
  logic        i_done;
  logic        o_mem_en, o_mem_we;
  logic [14:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic [7:0]  o_tx_byte;
  logic        o_tx_start;
  logic        i_tx_busy;
  logic        o_busy, o_dropped;
  logic [3:0]  o_state;

  logic txmBusy = 1'b0;
  logic holdBusy = 1'b0;
  assign i_tx_busy = txmBusy | holdBusy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  txLog[$];
  int          txStartCount = 0, wrCount = 0, rdCount = 0, dropCount = 0;
  logic [14:0] lastWrAddr;
  logic [31:0] lastWrData;
  logic [31:0] envMem[int];
  logic [31:0] refMem[int];
  logic        memReq;
  logic [14:0] memReqAddr;

  logic [7:0]  expQ[$];
  int          baseTx, baseWr, baseRd, baseDrop, expWr, expRd;
  logic [14:0] expAddr;
  logic [31:0] expData;

  command_executor dut (
    .clock(clock), .reset(reset),
    .i_address(i_address), .i_data(i_data), .i_readwrite(i_readwrite),
    .i_error(i_error), .i_done(i_done),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .o_tx_byte(o_tx_byte), .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy),
    .o_busy(o_busy), .o_dropped(o_dropped), .o_state(o_state)
  );

  // Free-running 10-unit clock.
  initial forever #5 clock = ~clock;

  function automatic logic [31:0] initVal(input int a);
    logic [31:0] t;
    t = 32'(a) * 32'h0100_0193;
    return t ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] envRead(input int a);
    return envMem.exists(a) ? envMem[a] : initVal(a);
  endfunction

  function automatic logic [31:0] refRead(input int a);
    return refMem.exists(a) ? refMem[a] : initVal(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Mid-cycle monitor: counts strobes and pulses and applies memory writes.
  initial forever begin
    @(negedge clock);
    if (o_tx_start === 1'b1) txStartCount++;
    if (o_mem_en === 1'b1 && o_mem_we === 1'b1) begin
      wrCount++;
      lastWrAddr = o_mem_addr;
      lastWrData = o_mem_wdata;
      envMem[int'(o_mem_addr)] = o_mem_wdata;
    end
    if (o_mem_en === 1'b1 && o_mem_we === 1'b0) rdCount++;
    if (o_dropped === 1'b1) dropCount++;
  end

  // Synchronous memory: read data is valid only in the cycle after the request.
  initial begin
    i_mem_rdata = '0;
    forever begin
      @(negedge clock);
      memReq = (o_mem_en === 1'b1) && (o_mem_we === 1'b0);
      memReqAddr = o_mem_addr;
      @(posedge clock);
      #1;
      i_mem_rdata = memReq ? envRead(int'(memReqAddr)) : $urandom();
    end
  end

  // UART transmitter model: takes a byte on o_tx_start, then stays busy a while.
  initial forever begin
    @(negedge clock);
    if (o_tx_start === 1'b1) begin
      txLog.push_back(o_tx_byte);
      @(negedge clock);
      txmBusy = 1'b1;
      repeat ($urandom_range(3, 8)) @(negedge clock);
      txmBusy = 1'b0;
    end
  end

  // Waits for an idle executor, builds the expected response and pulses i_done.
  task automatic applyStimulus(input logic [14:0] addr, input logic [31:0] data,
                               input logic rw, input logic [1:0] err);
    int n;
    logic [31:0] v;
    n = 0;
    @(negedge clock);
    while ((o_busy !== 1'b0 || txmBusy) && n < 500) begin
      @(negedge clock);
      n++;
    end
    checkOutput("idle_wait", 32'(n < 500), 32'd1);
    baseTx = txLog.size();
    baseWr = wrCount;
    baseRd = rdCount;
    baseDrop = dropCount;
    expQ.delete();
    expAddr = addr;
    expData = data;
    expWr = 0;
    expRd = 0;
    if (err != 2'd0) begin
      expQ.push_back(8'hE0 + 8'(err));
    end else if (rw) begin
      v = refRead(int'(addr));
      for (int i = 0; i < 4; i++) expQ.push_back(8'(v >> (8 * i)));
      expRd = 1;
    end else begin
      expQ.push_back(8'h06);
      refMem[int'(addr)] = data;
      expWr = 1;
`ifdef EXEC_WRITE_ECHO_EN
      for (int i = 0; i < 4; i++) expQ.push_back(8'(data >> (8 * i)));
      expRd = 1;
`endif
    end
    i_address = addr;
    i_data = data;
    i_readwrite = rw;
    i_error = err;
    i_done = 1'b1;
    @(negedge clock);
    i_done = 1'b0;
    i_address = 15'($urandom());
    i_data = $urandom();
    i_readwrite = 1'($urandom());
    i_error = 2'($urandom());
  endtask

  // Waits for the executor to return to idle and compares the whole response.
  task automatic awaitResponse(input int expDrop);
    int n;
    n = 0;
    while (o_busy !== 1'b0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("response_timeout", 32'(n < 3000), 32'd1);
    checkOutput("tx_count", 32'(txLog.size() - baseTx), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++)
      if (baseTx + i < txLog.size()) checkOutput("tx_byte", 32'(txLog[baseTx + i]), 32'(expQ[i]));
    checkOutput("mem_writes", 32'(wrCount - baseWr), 32'(expWr));
    checkOutput("mem_reads", 32'(rdCount - baseRd), 32'(expRd));
    if (expWr != 0) begin
      checkOutput("write_addr", 32'(lastWrAddr), 32'(expAddr));
      checkOutput("write_data", lastWrData, expData);
    end
    checkOutput("dropped_pulses", 32'(dropCount - baseDrop), 32'(expDrop));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_state"}, 32'(o_state), 32'd0);
    checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
    checkOutput({tag, "_tx_start"}, 32'(o_tx_start), 32'd0);
    checkOutput({tag, "_tx_byte"}, 32'(o_tx_byte), 32'd0);
    checkOutput({tag, "_mem_en"}, 32'(o_mem_en), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(o_mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(o_mem_addr), 32'd0);
    checkOutput({tag, "_mem_wdata"}, o_mem_wdata, 32'd0);
    checkOutput({tag, "_dropped"}, 32'(o_dropped), 32'd0);
  endtask

  // Directed scenarios followed by a random command stream.
  initial begin
    int n, snapStart, snapWr, snapRd;
    reset = 1'b1;
    i_done = 1'b0;
    i_address = '0;
    i_data = '0;
    i_readwrite = 1'b0;
    i_error = '0;
    repeat (3) @(negedge clock);
    checkAllZero("reset");
    reset = 1'b0;

    // Reset wins over a simultaneous i_done.
    @(negedge clock);
    reset = 1'b1;
    i_done = 1'b1;
    i_readwrite = 1'b1;
    i_address = 15'h0033;
    @(negedge clock);
    reset = 1'b0;
    i_done = 1'b0;
    checkOutput("reset_vs_done_busy", 32'(o_busy), 32'd0);
    checkOutput("reset_vs_done_mem_en", 32'(o_mem_en), 32'd0);

    // Write 0x0010 <= DEADBEEF: one write strobe in cycle N+1.
    applyStimulus(15'h0010, 32'hDEADBEEF, 1'b0, 2'd0);
    checkOutput("write_strobe_en", 32'(o_mem_en), 32'd1);
    checkOutput("write_strobe_we", 32'(o_mem_we), 32'd1);
    checkOutput("write_strobe_addr", 32'(o_mem_addr), 32'h0010);
    checkOutput("write_strobe_data", o_mem_wdata, 32'hDEADBEEF);
    @(negedge clock);
    checkOutput("write_strobe_one_cycle", 32'(o_mem_we), 32'd0);
    awaitResponse(0);

    // Read 0x0010 holding 12345678: bytes 78,56,34,12.
    applyStimulus(15'h0010, 32'h12345678, 1'b0, 2'd0);
    awaitResponse(0);
    applyStimulus(15'h0010, 32'h0, 1'b1, 2'd0);
    checkOutput("read_strobe_en", 32'(o_mem_en), 32'd1);
    checkOutput("read_strobe_we", 32'(o_mem_we), 32'd0);
    checkOutput("read_strobe_addr", 32'(o_mem_addr), 32'h0010);
    awaitResponse(0);
    checkOutput("read_first_byte", 32'(txLog[baseTx]), 32'h78);

    // Decoder error takes priority: single NAK byte, start in N+1.
    applyStimulus(15'h0010, 32'h0, 1'b1, 2'b10);
    checkOutput("nak_start", 32'(o_tx_start), 32'd1);
    checkOutput("nak_byte", 32'(o_tx_byte), 32'hE2);
    checkOutput("nak_no_mem", 32'(o_mem_en), 32'd0);
    awaitResponse(0);

    // Transmitter busy for 20 cycles while the first byte waits.
    holdBusy = 1'b1;
    applyStimulus(15'h0010, 32'h0, 1'b1, 2'd0);
    repeat (2) @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      checkOutput("held_busy_no_start", 32'(o_tx_start), 32'd0);
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    holdBusy = 1'b0;
    @(negedge clock);
    checkOutput("start_after_busy", 32'(o_tx_start), 32'd1);
    checkOutput("byte_after_busy", 32'(o_tx_byte), 32'h78);
    awaitResponse(0);

    // i_done while a response is in flight is dropped once.
    applyStimulus(15'h0010, 32'h0, 1'b1, 2'd0);
    n = 0;
    while (txLog.size() <= baseTx && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput("first_byte_wait", 32'(n < 200), 32'd1);
    repeat (2) @(negedge clock);
    i_address = 15'h0055;
    i_data = $urandom();
    i_readwrite = 1'b0;
    i_error = 2'd0;
    i_done = 1'b1;
    @(negedge clock);
    i_done = 1'b0;
    awaitResponse(1);

    // Random command stream over a small address window.
    for (int k = 0; k < 30; k++) begin
      logic [1:0] e;
      e = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      applyStimulus(15'($urandom_range(0, 7)), $urandom(), 1'($urandom()), e);
      awaitResponse(0);
    end

    // Reset during the second read byte abandons the rest of the response.
    applyStimulus(15'h0020, 32'hABCD0123, 1'b0, 2'd0);
    awaitResponse(0);
    applyStimulus(15'h0020, 32'h0, 1'b1, 2'd0);
    n = 0;
    while (txLog.size() < baseTx + 2 && n < 300) begin
      @(negedge clock);
      n++;
    end
    checkOutput("second_byte_wait", 32'(n < 300), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkAllZero("midop_reset");
    snapStart = txStartCount;
    snapWr = wrCount;
    snapRd = rdCount;
    repeat (30) @(negedge clock);
    checkOutput("no_start_after_reset", 32'(txStartCount - snapStart), 32'd0);
    checkOutput("no_write_after_reset", 32'(wrCount - snapWr), 32'd0);
    checkOutput("no_read_after_reset", 32'(rdCount - snapRd), 32'd0);
    checkOutput("bytes_before_reset", 32'(txLog.size() - baseTx), 32'd2);
    if (txLog.size() >= baseTx + 2) begin
      checkOutput("reset_byte0", 32'(txLog[baseTx]), 32'h23);
      checkOutput("reset_byte1", 32'(txLog[baseTx + 1]), 32'h01);
    end

    // Executor accepts new work after the reset.
    applyStimulus(15'h0020, 32'h0, 1'b1, 2'd0);
    awaitResponse(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
